dff_bank_arbiter: RTL and testbench

- Round-robin arbiter and sequencer sharing one bank of edge-triggered D-flip-flop storage registers between N_REQ requesters.
- Each requester runs a four-phase req/ack handshake to write or read one WIDTH-bit register.
- The block owns the bank's clock-enable and clear sequencing, so exactly one access occurs per grant.
- Sits between the requesting datapath blocks and the flip-flop register bank.

---
 rtl/dff_bank_arbiter_if.sv | 29 ++
 rtl/dff_bank_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the DFF bank arbiter.
// The master modport is the requester side; the slave modport is the arbiter side.
interface dff_bank_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N_REQ-1:0]       req;
    logic [N_REQ-1:0]       req_we;
    logic [N_REQ*AW-1:0]    req_addr;
    logic [N_REQ*WIDTH-1:0] req_wdata;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       rdata;
    logic                   busy;
    logic                   err;

    modport master (
        output req, req_we, req_addr, req_wdata,
        input  gnt, ack, rdata, busy, err
    );

    modport slave (
        input  req, req_we, req_addr, req_wdata,
        output gnt, ack, rdata, busy, err
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter/sequencer sharing one DFF register bank between N_REQ
// requesters. Each grant performs exactly one write or read of the bank.
// Optional feature: define ARB_TIMEOUT_EN to release a grant whose requester
// does not drop req within TIMEOUT cycles; err then latches high.
module dff_bank_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clear_n,
    dff_bank_arbiter_if.slave   bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_RELEASE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    win_q, win_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             we_q, we_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             busy_q;
    logic             err_q, err_d;
    logic [WIDTH-1:0] bank_q [DEPTH];
    logic [WIDTH-1:0] bank_d [DEPTH];

    logic [IW-1:0]    pick_c;
    logic             pick_vld_c;
    logic [IW-1:0]    idx_c;
    logic             addr_ok_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    cnt_q, cnt_d;
`else
    logic             unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // Pick the first pending requester at or above ptr, wrapping around.
    always_comb begin
        pick_c     = '0;
        pick_vld_c = 1'b0;
        idx_c      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_c = IW'((32'(ptr_q) + k) % N_REQ);
            if (!pick_vld_c && bus.req[idx_c]) begin
                pick_c     = idx_c;
                pick_vld_c = 1'b1;
            end
        end
    end

    // Addresses beyond the populated bank are accepted but do not touch storage.
    assign addr_ok_c = (32'(addr_q) < DEPTH);

    // Next-state, grant/ack sequencing and bank update.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        bank_d  = bank_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld_c) begin
                    win_d   = pick_c;
                    gnt_d   = N_REQ'(1) << pick_c;
                    we_d    = bus.req_we[pick_c];
                    addr_d  = bus.req_addr[32'(pick_c)*AW +: AW];
                    wdata_d = bus.req_wdata[32'(pick_c)*WIDTH +: WIDTH];
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (we_q) begin
                    if (addr_ok_c) begin
                        bank_d[addr_q] = wdata_q;
                    end
                end else begin
                    rdata_d = addr_ok_c ? bank_q[addr_q] : '0;
                end
                ack_d   = gnt_q;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.req[win_q]) begin
                    gnt_d   = '0;
                    ptr_d   = IW'((32'(win_q) + 1) % N_REQ);
                    state_d = S_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    ptr_d   = IW'((32'(win_q) + 1) % N_REQ);
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, pipeline and storage registers; clear_n aborts any transaction.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= (state_d != S_IDLE);
            err_q   <= err_d;
            bank_q  <= bank_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed self-checking bench for dff_bank_arbiter (N_REQ=4, WIDTH=8, DEPTH=4).
module tb_dff_bank_arbiter;
    logic clk;
    logic clear_n;
    int   total = 0;
    int   bad   = 0;

    dff_bank_arbiter_if #(.N_REQ(4), .WIDTH(8), .DEPTH(4)) bus ();

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [1:0] a, input logic [7:0] d);
        bus.req_we[i]          = we;
        bus.req_addr[i*2 +: 2] = a;
        bus.req_wdata[i*8 +: 8] = d;
        bus.req[i]             = 1'b1;
    endtask

    // One full handshake for requester idx; optionally re-raise req after release.
    task automatic do_round(input int idx, input bit reraise);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.gnt == '0 && n < 8);
        chk("gnt_lat",   32'(n), 32'd1);
        chk("gnt",       32'(bus.gnt), 32'(1) << idx);
        chk("busy",      32'(bus.busy), 32'd1);
        tick();
        chk("ack",       32'(bus.ack), 32'(1) << idx);
        tick();
        chk("ack_pulse", 32'(bus.ack), 32'd0);
        chk("gnt_hold",  32'(bus.gnt), 32'(1) << idx);
        bus.req[idx] = 1'b0;
        tick();
        chk("gnt_rel",   32'(bus.gnt), 32'd0);
        chk("busy_rel",  32'(bus.busy), 32'd0);
        if (reraise) bus.req[idx] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_n       = 1'b0;
        bus.req       = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(bus.gnt), 32'd0);
        chk("rst_ack",   32'(bus.ack), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_err",   32'(bus.err), 32'd0);
        clear_n = 1'b1;
        tick();

        // Single write of 0xA5 to addr 2, then read it back.
        set_req(1, 1'b1, 2'd2, 8'hA5);
        do_round(1, 1'b0);
        set_req(1, 1'b0, 2'd2, 8'h00);
        do_round(1, 1'b0);
        chk("rd_a5", 32'(bus.rdata), 32'hA5);

        // Reset asserted while the grant is held in RELEASE.
        set_req(0, 1'b1, 2'd1, 8'h3C);
        tick();
        tick();
        tick();
        chk("pre_rst_gnt", 32'(bus.gnt), 32'd1);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   32'(bus.gnt), 32'd0);
        chk("mid_rst_ack",   32'(bus.ack), 32'd0);
        chk("mid_rst_busy",  32'(bus.busy), 32'd0);
        chk("mid_rst_rdata", 32'(bus.rdata), 32'd0);
        bus.req = '0;
        tick();
        clear_n = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            set_req(3, 1'b0, 2'(a), 8'h00);
            do_round(3, 1'b0);
            chk("clr_reg", 32'(bus.rdata), 32'd0);
        end

        // Contention from ptr = 0: order 0,1,2,3,0.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'(i), 8'h00);
        do_round(0, 1'b1);
        do_round(1, 1'b1);
        do_round(2, 1'b1);
        do_round(3, 1'b1);
        do_round(0, 1'b0);
        bus.req = '0;

        // Write data changed after grant must be ignored.
        set_req(0, 1'b1, 2'd3, 8'h11);
        tick();
        chk("lat_gnt", 32'(bus.gnt), 32'd1);
        bus.req_wdata[7:0] = 8'hFF;
        bus.req_addr[1:0]  = 2'd0;
        tick();
        chk("lat_ack", 32'(bus.ack), 32'd1);
        tick();
        bus.req[0] = 1'b0;
        tick();
        chk("lat_rel", 32'(bus.gnt), 32'd0);
        set_req(0, 1'b0, 2'd3, 8'h00);
        do_round(0, 1'b0);
        chk("lat_data", 32'(bus.rdata), 32'h11);
        set_req(0, 1'b0, 2'd0, 8'h00);
        do_round(0, 1'b0);
        chk("lat_addr0", 32'(bus.rdata), 32'h00);

        // Wrap: after requester 3, req=1001 serves 0 then 3.
        set_req(3, 1'b0, 2'd3, 8'h00);
        do_round(3, 1'b0);
        set_req(0, 1'b0, 2'd3, 8'h00);
        set_req(3, 1'b0, 2'd3, 8'h00);
        do_round(0, 1'b0);
        do_round(3, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Requester 2 never releases; grant drops after TIMEOUT cycles in RELEASE.
        begin
            int n;
            set_req(2, 1'b0, 2'd0, 8'h00);
            set_req(3, 1'b0, 2'd0, 8'h00);
            tick();
            chk("to_gnt", 32'(bus.gnt), 32'h4);
            tick();
            chk("to_ack", 32'(bus.ack), 32'h4);
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.gnt != '0 && n < 30);
            chk("to_len", 32'(n), 32'd16);
            chk("to_err", 32'(bus.err), 32'd1);
            tick();
            chk("to_next", 32'(bus.gnt), 32'h8);
            clear_n = 1'b0;
            bus.req = '0;
            tick();
            clear_n = 1'b1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
